// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared FSM states, parity modes and oversampling constants for uart_cfg
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - show-ahead FIFO of 2**FIFO_W words; full/empty from an extra pointer MSB
module uart_fifo
  import uart_cfg_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] wdata,
  input  logic            rd,
  output logic [DBIT-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int DEPTH = 1 << FIFO_W;

  logic [DBIT-1:0] mem_q [DEPTH];
  logic [DBIT-1:0] mem_d [DEPTH];
  logic [FIFO_W:0] wptr_q, wptr_d;
  logic [FIFO_W:0] rptr_q, rptr_d;
  logic            do_wr, do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_W] != rptr_q[FIFO_W]) &&
                 (wptr_q[FIFO_W-1:0] == rptr_q[FIFO_W-1:0]);
  assign rdata = mem_q[rptr_q[FIFO_W-1:0]];

  // A read frees the slot being written when full, so both proceed.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) begin
      mem_d[wptr_q[FIFO_W-1:0]] = wdata;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_rd) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - runtime-configurable UART with TX/RX FIFOs and sticky errors
// UART_PARITY_EN adds the parity states and rx_parity_err.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 9,
  parameter int FIFO_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] divisor,
  input  logic [1:0]          parity_mode,
  input  logic                rx,
  output logic                tx,
  input  logic                tx_wr,
  input  logic [DBIT-1:0]     tx_data,
  output logic                tx_full,
  output logic                tx_busy,
  input  logic                rx_rd,
  output logic [DBIT-1:0]     rx_data,
  output logic                rx_empty,
  output logic                rx_frame_err,
  output logic                rx_parity_err,
  output logic                rx_overrun,
  input  logic                err_clr
);

  localparam logic [4:0] S_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] S_MID   = 5'(MID_SAMPLE);
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [3:0] N_LAST  = 4'(DBIT - 1);

  logic [DVSR_BIT-1:0] dvsr_eff, tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                txf_empty, txf_pop, rxf_full, rxf_push;
  logic [DBIT-1:0]     txf_rdata;
  tx_state_t           tx_state_q, tx_state_d;
  rx_state_t           rx_state_q, rx_state_d;
  logic [4:0]          tx_s_q, tx_s_d, rx_s_q, rx_s_d;
  logic [3:0]          tx_n_q, tx_n_d, rx_n_q, rx_n_d;
  logic [DBIT-1:0]     tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                tx_load;
  logic                rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic                frame_set, par_set, ovr_set;
  logic                ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
`ifdef UART_PARITY_EN
  logic                tx_pen_q, tx_pen_d, tx_pbit_q, tx_pbit_d;
  logic                rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
  logic                par_en;

  assign par_en = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
`else
  logic                unused_parity_mode;

  assign unused_parity_mode = ^parity_mode;
`endif

  // Comparing with >= lets a shrunken divisor take effect at the next wrap.
  assign dvsr_eff   = (divisor == '0) ? {{(DVSR_BIT-1){1'b0}}, 1'b1} : divisor;
  assign tick       = (tick_cnt_q >= dvsr_eff - 1'b1);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  assign rx_s1_d = rx;
  assign rx_s2_d = rx_s1_q;

  uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_wr), .wdata(tx_data), .rd(txf_pop),
    .rdata(txf_rdata), .full(tx_full), .empty(txf_empty)
  );

  uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rxf_push), .wdata(rx_sh_q), .rd(rx_rd),
    .rdata(rx_data), .full(rxf_full), .empty(rx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    txf_pop    = 1'b0;
`ifdef UART_PARITY_EN
    tx_pen_d   = tx_pen_q;
    tx_pbit_d  = tx_pbit_q;
`endif
    case (tx_state_q)
      TX_IDLE: tx_load = !txf_empty;
      TX_START: if (tick) begin
        if (tx_s_q == S_LAST) begin
          tx_s_d     = '0;
          tx_n_d     = '0;
          tx_state_d = TX_DATA;
        end else tx_s_d = tx_s_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tx_s_q == S_LAST) begin
          tx_s_d  = '0;
          tx_sh_d = {1'b0, tx_sh_q[DBIT-1:1]};
          if (tx_n_q == N_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
`else
            tx_state_d = TX_STOP;
`endif
          end else tx_n_d = tx_n_q + 1'b1;
        end else tx_s_d = tx_s_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tick) begin
        if (tx_s_q == S_LAST) begin
          tx_s_d     = '0;
          tx_state_d = TX_STOP;
        end else tx_s_d = tx_s_q + 1'b1;
      end
`endif
      TX_STOP: if (tick) begin
        if (tx_s_q == SB_LAST) begin
          tx_state_d = TX_IDLE;
          tx_load    = !txf_empty;
        end else tx_s_d = tx_s_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame settings are latched here so mid-frame changes wait for the next frame.
    if (tx_load) begin
      txf_pop    = 1'b1;
      tx_sh_d    = txf_rdata;
      tx_s_d     = '0;
      tx_state_d = TX_START;
`ifdef UART_PARITY_EN
      tx_pen_d   = par_en;
      tx_pbit_d  = (^txf_rdata) ^ (parity_mode == PAR_ODD);
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_sh_q[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx = tx_pbit_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state_q != TX_IDLE) || !txf_empty;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_sh_d    = rx_sh_q;
    rxf_push   = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
`ifdef UART_PARITY_EN
    rx_pen_d   = rx_pen_q;
    rx_podd_d  = rx_podd_q;
`endif
    case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_s_d     = '0;
        rx_state_d = RX_START;
`ifdef UART_PARITY_EN
        rx_pen_d   = par_en;
        rx_podd_d  = (parity_mode == PAR_ODD);
`endif
      end
      RX_START: if (tick) begin
        if (rx_s_q == S_MID) begin
          rx_s_d     = '0;
          rx_n_d     = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (rx_s_q == S_LAST) begin
          rx_s_d  = '0;
          rx_sh_d = {rx_s2_q, rx_sh_q[DBIT-1:1]};
          if (rx_n_q == N_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
`else
            rx_state_d = RX_STOP;
`endif
          end else rx_n_d = rx_n_q + 1'b1;
        end else rx_s_d = rx_s_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (tick) begin
        if (rx_s_q == S_LAST) begin
          rx_s_d     = '0;
          par_set    = rx_s2_q != ((^rx_sh_q) ^ rx_podd_q);
          rx_state_d = RX_STOP;
        end else rx_s_d = rx_s_q + 1'b1;
      end
`endif
      RX_STOP: if (tick) begin
        if (rx_s_q == SB_LAST) begin
          rxf_push   = 1'b1;
          frame_set  = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A same-cycle pop makes room, so only an unrelieved full FIFO overruns.
  assign ovr_set = rxf_push && rxf_full && !rx_rd;
  assign ferr_d  = err_clr ? 1'b0 : (ferr_q | frame_set);
  assign perr_d  = err_clr ? 1'b0 : (perr_q | par_set);
  assign ovr_d   = err_clr ? 1'b0 : (ovr_q | ovr_set);

  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_sh_q    <= '0;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_PARITY_EN
      tx_pen_q   <= 1'b0;
      tx_pbit_q  <= 1'b0;
      rx_pen_q   <= 1'b0;
      rx_podd_q  <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_sh_q    <= tx_sh_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
`ifdef UART_PARITY_EN
      tx_pen_q   <= tx_pen_d;
      tx_pbit_q  <= tx_pbit_d;
      rx_pen_q   <= rx_pen_d;
      rx_podd_q  <= rx_podd_d;
`endif
    end
  end

endmodule
